// File: rtl/pov_sched_pkg.sv
// POV update scheduler shared definitions.
// State codes, grant codes and skip counter width.
package pov_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_LOAD = 2'd2,
    ST_SKIP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_SPI  = 2'b01,
    GNT_DEMO = 2'b10
  } grant_e;

  localparam int SKIP_W = 8;
  localparam logic [SKIP_W-1:0] SKIP_MAX = '1;

  // Saturating add of a small bump to the skip counter.
  function automatic logic [SKIP_W-1:0] sat_add(
    input logic [SKIP_W-1:0] cnt,
    input logic [1:0]        bump
  );
    logic [SKIP_W:0] sum;
    sum = {1'b0, cnt} + {{(SKIP_W-1){1'b0}}, bump};
    return sum[SKIP_W] ? SKIP_MAX : sum[SKIP_W-1:0];
  endfunction

endpackage

// File: rtl/pov_sched_if.sv
// POV scheduler control bundle.
// Master drives frame/tracer/request inputs; slave is the scheduler.
interface pov_sched_if
  import pov_sched_pkg::*;
#(
  parameter int DIV_W = 4
) ();

  logic              i_frame_end;
  logic [DIV_W-1:0]  i_frame_div;
  logic              i_trace_busy;
  logic              i_spi_ready;
  logic              i_req_px;
  logic              i_req_py;
  logic              o_load_if_ready;
  logic              o_inc_px;
  logic              o_inc_py;
  logic [1:0]        o_grant;
  logic              o_busy;
  logic [SKIP_W-1:0] o_skip_count;

  modport master (
    output i_frame_end, i_frame_div, i_trace_busy,
    output i_spi_ready, i_req_px, i_req_py,
    input  o_load_if_ready, o_inc_px, o_inc_py,
    input  o_grant, o_busy, o_skip_count
  );

  modport slave (
    input  i_frame_end, i_frame_div, i_trace_busy,
    input  i_spi_ready, i_req_px, i_req_py,
    output o_load_if_ready, o_inc_px, o_inc_py,
    output o_grant, o_busy, o_skip_count
  );

endinterface

// File: rtl/pov_sched_rr_arb2.sv
// Two-requester round-robin arbiter (SPI vs demo).
// Last winner only moves when a grant is actually taken.
module pov_sched_rr_arb2
  import pov_sched_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_spi,
  input  logic   req_demo,
  input  logic   advance,
  output grant_e gnt
);

  logic last_demo_q, last_demo_d;

  // Pick winner; on conflict favour whoever did not win last.
  always_comb begin
    gnt = GNT_NONE;
    unique case ({req_spi, req_demo})
      2'b11:   gnt = last_demo_q ? GNT_SPI : GNT_DEMO;
      2'b10:   gnt = GNT_SPI;
      2'b01:   gnt = GNT_DEMO;
      default: gnt = GNT_NONE;
    endcase
  end

  // Remember the winner of the grant being taken.
  always_comb begin
    last_demo_d = last_demo_q;
    if (advance && gnt != GNT_NONE) last_demo_d = (gnt == GNT_DEMO);
  end

  // Reset to demo so the first conflict goes to SPI.
  always_ff @(posedge clk) begin
    if (!rst_n) last_demo_q <= 1'b1;
    else        last_demo_q <= last_demo_d;
  end

endmodule

// File: rtl/pov_sched.sv
// POV update scheduler: frame divider, tracer-quiet wait,
// SPI/demo arbitration and skip accounting. Control only.
module pov_sched
  import pov_sched_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int DIV_W   = 4
) (
  input logic        clk,
  input logic        reset_n,
  pov_sched_if.slave bus
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  fcnt_q, fcnt_d;
  logic              pend_q, pend_d;
  logic [15:0]       tmo_q, tmo_d;
  logic              load_q, load_d;
  logic              px_q, px_d;
  logic              py_q, py_d;
  logic              busy_q, busy_d;
  grant_e            grant_q, grant_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [1:0]        bump;
  logic              match;
  logic              req_demo;
  logic              go_load;
  grant_e            arb_gnt;

  assign req_demo = bus.i_req_px | bus.i_req_py;

  pov_sched_rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (reset_n),
    .req_spi  (bus.i_spi_ready),
    .req_demo (req_demo),
    .advance  (go_load),
    .gnt      (arb_gnt)
  );

  // Frame divider; a counter above a lowered divide wraps too.
  always_comb begin
    match  = bus.i_frame_end && (fcnt_q >= bus.i_frame_div);
    fcnt_d = fcnt_q;
    if (bus.i_frame_end) fcnt_d = match ? '0 : fcnt_q + 1'b1;
  end

  // Slot FSM next state and registered output values.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | match;
    tmo_d   = tmo_q;
    grant_d = grant_q;
    load_d  = 1'b0;
    px_d    = 1'b0;
    py_d    = 1'b0;
    go_load = 1'b0;
    bump    = {1'b0, match && (state_q != ST_IDLE)};
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q || match) begin
          state_d = ST_ARM;
          pend_d  = 1'b0;
          tmo_d   = '0;
        end
      end
      ST_ARM: begin
        if (!bus.i_trace_busy) begin
          if (bus.i_spi_ready || req_demo) begin
            state_d = ST_LOAD;
            go_load = 1'b1;
            load_d  = 1'b1;
            grant_d = arb_gnt;
            if (arb_gnt == GNT_DEMO) begin
              px_d = bus.i_req_px;
              py_d = bus.i_req_py;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_SKIP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_SKIP: begin
        state_d = ST_IDLE;
        bump    = bump + 2'd1;
      end
    endcase
    skip_d = sat_add(skip_q, bump);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      tmo_q   <= '0;
      load_q  <= 1'b0;
      px_q    <= 1'b0;
      py_q    <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= GNT_NONE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      load_q  <= load_d;
      px_q    <= px_d;
      py_q    <= py_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      skip_q  <= skip_d;
    end
  end

  assign bus.o_load_if_ready = load_q;
  assign bus.o_inc_px        = px_q;
  assign bus.o_inc_py        = py_q;
  assign bus.o_grant         = grant_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_skip_count    = skip_q;

endmodule

// File: tb/tb_pov_sched.sv
// Bench for pov_sched: directed scenarios with literal
// expectations plus random traffic against a slot-level model.
module tb_pov_sched;

  localparam int TMO = 16;
  localparam int DW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fe = 1'b0;
  logic [DW-1:0] div = '0;
  logic busy = 1'b0;
  logic spi = 1'b0;
  logic px = 1'b0;
  logic py = 1'b0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pov_sched_if #(.DIV_W(DW)) bus ();

  assign bus.i_frame_end  = fe;
  assign bus.i_frame_div  = div;
  assign bus.i_trace_busy = busy;
  assign bus.i_spi_ready  = spi;
  assign bus.i_req_px     = px;
  assign bus.i_req_py     = py;

  pov_sched #(.TIMEOUT(TMO), .DIV_W(DW)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Slot-level model: phase 0 idle, 1 waiting for quiet,
  // 2 strobing, 3 skipping.
  int m_cnt, m_phase, m_age, m_grant, m_skip;
  bit m_pend, m_last_demo, m_px, m_py;

  always @(posedge clk) begin : model
    bit mt, dm, wd;
    int add;
    if (!rst_n) begin
      m_cnt = 0; m_phase = 0; m_age = 0; m_grant = 0;
      m_skip = 0; m_pend = 0; m_last_demo = 1;
      m_px = 0; m_py = 0;
    end else begin
      mt = fe && (m_cnt >= int'(div));
      if (fe) m_cnt = mt ? 0 : m_cnt + 1;
      add = (mt && m_phase != 0) ? 1 : 0;
      m_px = 0; m_py = 0;
      case (m_phase)
        0: if (m_pend || mt) begin
             m_phase = 1; m_pend = 0; m_age = 0;
           end
        1: begin
          m_pend |= mt;
          if (!busy) begin
            dm = px || py;
            if (spi || dm) begin
              wd = (spi && dm) ? !m_last_demo : dm;
              m_last_demo = wd;
              m_grant = wd ? 2 : 1;
              m_px = wd && px;
              m_py = wd && py;
              m_phase = 2;
            end else m_phase = 0;
          end else begin
            m_age++;
            if (m_age == TMO) m_phase = 3;
          end
        end
        2: begin m_pend |= mt; m_phase = 0; end
        default: begin
          m_pend |= mt; add++; m_phase = 0;
        end
      endcase
      m_skip = (m_skip + add > 255) ? 255 : m_skip + add;
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_load", bus.o_load_if_ready, m_phase == 2);
      chk("m_busy", bus.o_busy, m_phase != 0);
      chk("m_grant", bus.o_grant, m_grant);
      chk("m_inc_px", bus.o_inc_px, m_px);
      chk("m_inc_py", bus.o_inc_py, m_py);
      chk("m_skip", bus.o_skip_count, m_skip);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; fe = 0; busy = 0; spi = 0; px = 0; py = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // Returns on the negedge one cycle after the pulse edge.
  task automatic pulse();
    @(negedge clk) fe = 1;
    @(negedge clk) fe = 0;
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, first, second, bcnt;
    int gq[$];
    int pq[$];
    int exp_g[4];
    int exp_p[4];
    exp_g = '{1, 2, 1, 2};
    exp_p = '{0, 1, 0, 1};

    do_reset();
    chk_en = 1;
    @(negedge clk);
    chk("rst_load", bus.o_load_if_ready, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_grant", bus.o_grant, 0);
    chk("rst_inc", {bus.o_inc_px, bus.o_inc_py}, 0);
    chk("rst_skip", bus.o_skip_count, 0);

    // Single-frame latency with SPI.
    div = 0; spi = 1;
    pulse();
    chk("lat_t1_load", bus.o_load_if_ready, 0);
    chk("lat_t1_busy", bus.o_busy, 1);
    @(negedge clk);
    chk("lat_t2_load", bus.o_load_if_ready, 1);
    chk("lat_t2_grant", bus.o_grant, 1);
    chk("lat_t2_inc", {bus.o_inc_px, bus.o_inc_py}, 0);
    @(negedge clk);
    chk("lat_t3_load", bus.o_load_if_ready, 0);

    // Divide by three.
    do_reset();
    div = 2; spi = 1; n = 0; first = 0; second = 0;
    for (int p = 1; p <= 6; p++) begin
      pulse();
      repeat (4) begin
        if (bus.o_load_if_ready) begin
          n++;
          if (n == 1) first = p;
          else second = p;
        end
        @(negedge clk);
      end
    end
    chk("div3_strobes", n, 2);
    chk("div3_first", first, 3);
    chk("div3_second", second, 6);

    // Round-robin on persistent conflict.
    do_reset();
    div = 0; spi = 1; px = 1;
    for (int s = 0; s < 4; s++) begin
      pulse();
      repeat (4) begin
        if (bus.o_load_if_ready) begin
          gq.push_back(int'(bus.o_grant));
          pq.push_back(int'(bus.o_inc_px));
        end
        @(negedge clk);
      end
    end
    chk("rr_count", gq.size(), 4);
    for (int s = 0; s < 4 && s < gq.size(); s++) begin
      chk($sformatf("rr_grant%0d", s), gq[s], exp_g[s]);
      chk($sformatf("rr_px%0d", s), pq[s], exp_p[s]);
    end

    // Timeout skip and saturation.
    do_reset();
    div = 0; spi = 1; busy = 1;
    pulse();
    bcnt = 0;
    for (int c = 0; c < 40 && bus.o_busy; c++) begin
      bcnt++;
      chk("to_noload", bus.o_load_if_ready, 0);
      @(negedge clk);
    end
    chk("to_busy_cycles", bcnt, TMO + 1);
    chk("to_skip1", bus.o_skip_count, 1);
    for (int s = 1; s < 300; s++) begin
      pulse();
      repeat (20) @(negedge clk);
    end
    chk("to_sat", bus.o_skip_count, 255);

    // Busy falls, demo py request wins.
    do_reset();
    div = 0; busy = 1; py = 1;
    pulse();
    repeat (9) @(negedge clk);
    chk("bf_pre_load", bus.o_load_if_ready, 0);
    busy = 0;
    @(negedge clk);
    chk("bf_load", bus.o_load_if_ready, 1);
    chk("bf_inc_py", bus.o_inc_py, 1);
    chk("bf_inc_px", bus.o_inc_px, 0);
    chk("bf_grant", bus.o_grant, 2);

    // Reset in ARM with a frame pulse in the same cycle.
    do_reset();
    div = 0; spi = 1; busy = 1;
    pulse();
    chk("ra_in_arm", bus.o_busy, 1);
    rst_n = 0; fe = 1;
    @(negedge clk);
    rst_n = 1; fe = 0; busy = 0;
    chk("ra_load", bus.o_load_if_ready, 0);
    chk("ra_busy", bus.o_busy, 0);
    chk("ra_grant", bus.o_grant, 0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_load_if_ready || bus.o_busy) n++;
    end
    chk("ra_quiet", n, 0);
    pulse();
    @(negedge clk);
    chk("ra_next_load", bus.o_load_if_ready, 1);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) != 0);
      fe = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 49) == 0) div = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) busy = ~busy;
      spi = $urandom_range(0, 1);
      px = ($urandom_range(0, 2) == 0);
      py = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    fe = 0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
